// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter (CPU and debug/loader) in front of a single-port 16-bit RAM.
//
// Ports:
//   clk, arst_n                 clock and asynchronous active-low reset
//   c_req/c_we/c_byte/c_addr/c_wdata, c_gnt/c_rvalid
//                               CPU request port, grant and read-valid
//   d_req/d_we/d_byte/d_addr/d_wdata/d_lock, d_gnt/d_rvalid
//                               debug request port (with atomic lock), grant and read-valid
//   rdata                       read data shared by both ports, qualified by the owner's rvalid
//   ram_en/ram_we/ram_addr/ram_be/ram_wdata/ram_rdata
//                               RAM side; read data arrives one cycle after the strobe
//
// Grants are combinational in the request cycle. Contention alternates between ports, except
// that a locking debug owner may keep the RAM for up to LOCK_MAX consecutive contended grants.
module ram_arbiter #(
    parameter int unsigned LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic        c_byte,
    input  logic [15:0] c_addr,
    input  logic [15:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic        d_byte,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [15:0] rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [14:0] ram_addr,
    output logic [1:0]  ram_be,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata
);

    localparam int unsigned CntW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(LOCK_MAX);

    typedef enum logic {OwnCpu = 1'b0, OwnDbg = 1'b1} owner_e;

    owner_e          last_owner_q, last_owner_d;
    logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
    logic            pend_valid_q, pend_valid_d;
    owner_e          pend_owner_q, pend_owner_d;
    logic            pend_byte_q, pend_byte_d;
    logic            pend_a0_q, pend_a0_d;

    logic        lock_ok;
    logic        c_win, d_win;
    logic        sel_we, sel_byte;
    logic [15:0] sel_addr, sel_wdata;

    // Debug keeps ownership only if it already holds the RAM and has budget left.
    assign lock_ok = d_lock && (last_owner_q == OwnDbg) && (lock_cnt_q < CntMax);

    always_comb begin
        c_win = 1'b0;
        d_win = 1'b0;
        if (c_req && d_req) begin
            if (lock_ok || (last_owner_q == OwnCpu)) begin
                d_win = 1'b1;
            end else begin
                c_win = 1'b1;
            end
        end else begin
            c_win = c_req;
            d_win = d_req;
        end
    end

    // Grants are combinational, so they are forced low while reset is held.
    assign c_gnt = c_win & arst_n;
    assign d_gnt = d_win & arst_n;

    assign sel_we    = d_gnt ? d_we    : c_we;
    assign sel_byte  = d_gnt ? d_byte  : c_byte;
    assign sel_addr  = d_gnt ? d_addr  : c_addr;
    assign sel_wdata = d_gnt ? d_wdata : c_wdata;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_be    = 2'b00;
        ram_wdata = '0;
        if (c_gnt || d_gnt) begin
            ram_en    = 1'b1;
            ram_we    = sel_we;
            ram_addr  = sel_addr[15:1];
            ram_be    = sel_byte ? (sel_addr[0] ? 2'b10 : 2'b01) : 2'b11;
            // Replicate the byte so either lane picks it up.
            ram_wdata = sel_byte ? {sel_wdata[7:0], sel_wdata[7:0]} : sel_wdata;
        end
    end

    always_comb begin
        last_owner_d = last_owner_q;
        lock_cnt_d   = lock_cnt_q;
        pend_valid_d = ram_en && !sel_we;
        pend_owner_d = d_gnt ? OwnDbg : OwnCpu;
        pend_byte_d  = sel_byte;
        pend_a0_d    = sel_addr[0];

        if (c_gnt) begin
            last_owner_d = OwnCpu;
        end else if (d_gnt) begin
            last_owner_d = OwnDbg;
        end

        if (c_gnt || !d_lock) begin
            lock_cnt_d = '0;
        end else if (d_gnt && c_req && (lock_cnt_q < CntMax)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            last_owner_q <= OwnDbg;
            lock_cnt_q   <= '0;
            pend_valid_q <= 1'b0;
            pend_owner_q <= OwnCpu;
            pend_byte_q  <= 1'b0;
            pend_a0_q    <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
            lock_cnt_q   <= lock_cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_owner_q <= pend_owner_d;
            pend_byte_q  <= pend_byte_d;
            pend_a0_q    <= pend_a0_d;
        end
    end

    assign c_rvalid = pend_valid_q && (pend_owner_q == OwnCpu);
    assign d_rvalid = pend_valid_q && (pend_owner_q == OwnDbg);

    always_comb begin
        rdata = '0;
        if (arst_n && pend_valid_q) begin
            if (pend_byte_q) begin
                rdata = {8'h00, (pend_a0_q ? ram_rdata[15:8] : ram_rdata[7:0])};
            end else begin
                rdata = ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a behavioural model.
module tb_ram_arbiter;

    localparam int unsigned LOCK_MAX = 8;

    logic        clk;
    logic        arst_n;
    logic        c_req, c_we, c_byte;
    logic [15:0] c_addr, c_wdata;
    logic        c_gnt, c_rvalid;
    logic        d_req, d_we, d_byte, d_lock;
    logic [15:0] d_addr, d_wdata;
    logic        d_gnt, d_rvalid;
    logic [15:0] rdata;
    logic        ram_en, ram_we;
    logic [14:0] ram_addr;
    logic [1:0]  ram_be;
    logic [15:0] ram_wdata, ram_rdata;

    ram_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_byte    (c_byte),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_byte    (d_byte),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_lock    (d_lock),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .rdata     (rdata),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_be    (ram_be),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model state: who owned the RAM last, how many locked grants in a row,
    // and reads still waiting for their data.
    typedef struct {bit dbg; bit byt; bit a0;} rd_t;
    rd_t pend[$];
    bit  m_last_dbg = 1'b1;
    int  m_locked   = 0;

    task automatic model_reset();
        pend.delete();
        m_last_dbg = 1'b1;
        m_locked   = 0;
    endtask

    // Compare every DUT output against the model for the inputs currently applied,
    // then advance the model as if the next rising edge had happened.
    task automatic check_cycle();
        bit        gc, gd, ev_c, ev_d;
        bit [15:0] ev_rd, a, w;
        bit        we, byt;
        bit [1:0]  be;
        rd_t       r;
        if (!arst_n) begin
            check("rst_c_gnt", c_gnt, 0);
            check("rst_d_gnt", d_gnt, 0);
            check("rst_c_rvalid", c_rvalid, 0);
            check("rst_d_rvalid", d_rvalid, 0);
            check("rst_ram_en", ram_en, 0);
            check("rst_ram_we", ram_we, 0);
            check("rst_ram_be", ram_be, 0);
            check("rst_rdata", rdata, 0);
            model_reset();
            return;
        end
        ev_c = 0; ev_d = 0; ev_rd = 0;
        if (pend.size() > 0) begin
            r = pend.pop_front();
            ev_c = !r.dbg;
            ev_d = r.dbg;
            if (!r.byt) ev_rd = ram_rdata;
            else ev_rd = {8'h00, (r.a0 ? ram_rdata[15:8] : ram_rdata[7:0])};
        end
        if (c_req && d_req) begin
            if (d_lock && m_last_dbg && m_locked < LOCK_MAX) gd = 1;
            else gd = !m_last_dbg;
            gc = !gd;
        end else begin
            gc = c_req;
            gd = d_req;
        end
        check("c_gnt", c_gnt, gc);
        check("d_gnt", d_gnt, gd);
        check("c_rvalid", c_rvalid, ev_c);
        check("d_rvalid", d_rvalid, ev_d);
        if (ev_c || ev_d) check("rdata", rdata, ev_rd);
        check("ram_en", ram_en, gc || gd);
        if (gc || gd) begin
            we  = gd ? d_we : c_we;
            byt = gd ? d_byte : c_byte;
            a   = gd ? d_addr : c_addr;
            w   = gd ? d_wdata : c_wdata;
            be  = !byt ? 2'b11 : (a % 2 == 1) ? 2'b10 : 2'b01;
            check("ram_we", ram_we, we);
            check("ram_addr", ram_addr, a / 2);
            check("ram_be", ram_be, be);
            check("ram_wdata", ram_wdata, byt ? (w % 256) * 257 : w);
            if (!we) pend.push_back('{dbg: gd, byt: byt, a0: a % 2 == 1});
            m_last_dbg = gd;
        end else begin
            check("idle_ram_we", ram_we, 0);
            check("idle_ram_addr", ram_addr, 0);
            check("idle_ram_be", ram_be, 0);
            check("idle_ram_wdata", ram_wdata, 0);
        end
        if (gc || !d_lock) m_locked = 0;
        else if (gd && c_req && m_locked < LOCK_MAX) m_locked++;
    endtask

    task automatic drive(input bit rst, input bit cr, input bit cw, input bit cb,
                         input bit [15:0] ca, input bit [15:0] cwd,
                         input bit dr, input bit dw, input bit db, input bit [15:0] da,
                         input bit [15:0] dwd, input bit dl, input bit [15:0] rrd);
        @(negedge clk);
        arst_n = rst;
        c_req = cr; c_we = cw; c_byte = cb; c_addr = ca; c_wdata = cwd;
        d_req = dr; d_we = dw; d_byte = db; d_addr = da; d_wdata = dwd; d_lock = dl;
        ram_rdata = rrd;
        #1;
        check_cycle();
    endtask

    task automatic idle(input bit [15:0] rrd);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rrd);
    endtask

    bit lock_r;

    initial begin
        arst_n = 0;
        {c_req, c_we, c_byte, d_req, d_we, d_byte, d_lock} = '0;
        {c_addr, c_wdata, d_addr, d_wdata, ram_rdata} = '0;

        // Reset held with both ports requesting.
        drive(0, 1, 0, 0, 16'h1234, 0, 1, 0, 0, 16'h4321, 0, 0, 16'hFFFF);
        drive(0, 1, 1, 0, 16'h1234, 0, 1, 1, 0, 16'h4321, 0, 1, 16'hFFFF);

        // Continuous contention without lock: C, D, C, D ...
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 1, 0, 16'h0100, 16'h1111, 1, 1, 0, 16'h0200, 16'h2222, 0, 0);
            check("alt_c", c_gnt, (i % 2) == 0);
        end
        idle(0);

        // CPU word read at 0x0010, data 0xBEEF the following cycle.
        drive(1, 1, 0, 0, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
        check("wr_rd_addr", ram_addr, 15'h0008);
        check("wr_rd_be", ram_be, 2'b11);
        idle(16'hBEEF);
        check("wr_rd_rvalid", c_rvalid, 1);
        check("wr_rd_rdata", rdata, 16'hBEEF);

        // Debug byte write at 0x0021.
        drive(1, 0, 0, 0, 0, 0, 1, 1, 1, 16'h0021, 16'h12AB, 0, 0);
        check("bw_addr", ram_addr, 15'h0010);
        check("bw_be", ram_be, 2'b10);
        check("bw_wdata", ram_wdata, 16'hABAB);
        idle(0);
        check("bw_no_rvalid", c_rvalid | d_rvalid, 0);

        // Lock: after a CPU grant, debug holds for LOCK_MAX contended cycles, then CPU.
        drive(1, 1, 1, 0, 16'h0002, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < LOCK_MAX + 1; i++) begin
            drive(1, 1, 1, 0, 16'h0004, 0, 1, 1, 0, 16'h0006, 0, 1, 0);
            check("lock_d", d_gnt, i < LOCK_MAX);
        end
        idle(0);

        // CPU byte read at 0x0003, then a debug read immediately after.
        drive(1, 1, 0, 1, 16'h0003, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 16'h0040, 0, 0, 16'h5A77);
        check("b2b_c_rvalid", c_rvalid, 1);
        check("b2b_rdata", rdata, 16'h005A);
        idle(16'h1357);
        check("b2b_d_rvalid", d_rvalid, 1);
        check("b2b_c_quiet", c_rvalid, 0);

        // Reset during the cycle after an accepted read.
        drive(1, 1, 0, 0, 16'h0010, 0, 1, 0, 0, 16'h0020, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'hBEEF);
        check("rst_drop_rvalid", c_rvalid | d_rvalid, 0);
        drive(1, 1, 0, 0, 16'h0010, 0, 1, 0, 0, 16'h0020, 0, 0, 16'hBEEF);
        check("rst_first_c", c_gnt, 1);
        check("rst_no_stale", c_rvalid | d_rvalid, 0);

        // Randomized traffic with bursts of locking.
        lock_r = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) lock_r = !lock_r;
            if ($urandom_range(0, 299) == 0) begin
                drive(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 16'($urandom));
            end else begin
                drive(1, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                      16'($urandom), 16'($urandom),
                      $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                      16'($urandom), 16'($urandom), lock_r, 16'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 8, is the maximum number of consecutive debug-port grants under lock while the CPU waits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 arst_n  input  1  reset, asynchronous, active-low.
REQ-004 c_req  input  1  CPU port access request.
REQ-005 c_we  input  1  CPU write (1) / read (0).
REQ-006 c_byte  input  1  CPU byte-mode access.
REQ-007 c_addr  input  16  CPU byte address.
REQ-008 c_wdata  input  16  CPU write data; byte writes use [7:0].
REQ-009 c_gnt  output  1  CPU request accepted this cycle.
REQ-010 c_rvalid  output  1  CPU read data valid.
REQ-011 d_req  input  1  debug/loader port request.
REQ-012 d_we  input  1  debug write/read.
REQ-013 d_byte  input  1  debug byte-mode access.
REQ-014 d_addr  input  16  debug byte address.
REQ-015 d_wdata  input  16  debug write data.
REQ-016 d_lock  input  1  debug requests atomic back-to-back ownership (read-modify-write).
REQ-017 d_gnt  output  1  debug request accepted this cycle.
REQ-018 d_rvalid  output  1  debug read data valid.
REQ-019 rdata  output  16  read data returned to both ports; qualified only by the owning port's rvalid.
REQ-020 ram_en, ram_we  output  1 each  RAM access strobe and write enable.
REQ-021 ram_addr  output  15  RAM word address.
REQ-022 ram_be  output  2  byte-lane enables: [0] is the low byte, [1] is the high byte.
REQ-023 ram_wdata  output  16  RAM write data.
REQ-024 ram_rdata  input  16  RAM read data, valid one cycle after a read strobe.

Function
REQ-025 Grants are combinational in the request cycle: exactly one of c_gnt/d_gnt is high when any request is high, and neither is high otherwise; req&gnt means the access is accepted.
REQ-026 With a single requester, that requester is granted.
REQ-027 With both requesting and the lock rule inactive, the port not granted most recently wins; the last_owner register resets to debug, so the CPU wins the first contention.
REQ-028 Lock rule: d_lock=1, last_owner=debug and lock_cnt<LOCK_MAX -> debug wins the contention.
REQ-029 lock_cnt increments, saturating at LOCK_MAX, on each debug grant under contention with d_lock=1; it clears on any CPU grant or on any cycle with d_lock=0.
REQ-030 The RAM is driven combinationally from the granted port:
- ram_en = any grant;
- ram_we = winner's we;
- ram_addr = addr[15:1];
- ram_be = 2'b11 for word accesses, and for byte accesses addr[0] ? 2'b10 : 2'b01;
- byte writes drive ram_wdata = {wdata[7:0], wdata[7:0]}.
REQ-031 An accepted read registers pending owner, byte flag and addr[0]; the next cycle asserts the owner's rvalid for exactly one cycle.
REQ-032 rdata is ram_rdata for word reads; for byte reads it is the selected lane, zero-extended to 16 bits.
REQ-033 Writes produce no rvalid.
REQ-034 Back-to-back accesses are permitted every cycle, including a read followed immediately by an access from the other port; a read's rvalid is never lost or misrouted.
REQ-035 When no port is granted, ram_en=0, ram_we=0, ram_be=0, and ram_addr and ram_wdata are 0.

Reset
REQ-036 While arst_n=0:
- gnt outputs, rvalid outputs, ram_en, ram_we and ram_be are 0;
- rdata is 0;
- last_owner is debug;
- lock_cnt is 0;
- the pending read is cleared.
REQ-037 Reset asserted mid-read drops that read's rvalid; after release, the first access behaves as from idle.

Verification
REQ-038 Both ports request continuously with d_lock=0 -> grants alternate C,D,C,D starting with C.
REQ-039 CPU word read at addr 0x0010 with ram_rdata=0xBEEF -> ram_addr=0x0008 and ram_be=11; next cycle c_rvalid=1 and rdata=0xBEEF.
REQ-040 Debug byte write at addr 0x0021 with wdata=0x12AB -> ram_addr=0x0010, ram_be=10, ram_wdata=0xABAB; no rvalid.
REQ-041 d_lock=1 with both ports requesting and LOCK_MAX=8 -> after the first C grant, D is granted 8 consecutive cycles, then C.
REQ-042 CPU byte read at 0x0003 with ram_rdata=0x5A77, followed by a debug read granted the next cycle -> c_rvalid with rdata=0x005A, then d_rvalid one cycle later.
REQ-043 arst_n pulsed low in the cycle after an accepted read -> no rvalid; after release, C wins the first contention.
